multirate_fifo: RTL and testbench

Parametrised K-in/J-out circular FIFO with valid/ready handshakes on both sides, an occupancy counter, and synchronous flush. Writes are K-word blocks and reads are J-word blocks, with K and J independent. SIZE need not be a power of two, and pointers wrap per element modulo SIZE. It is the next-generation buffer datapath: it replaces the bare buffer, pointer register, adder and comparator cluster with a self-contained block carrying its own control.

---
 rtl/multirate_fifo.sv | 111 +++++++++++
 tb/tb_multirate_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multirate_fifo.sv
// K-word-in / J-word-out circular FIFO with valid/ready on both sides.
// Pointers wrap per element modulo SIZE, which need not be a power of two.
module multirate_fifo #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int J     = 4,
    parameter int BIT   = $clog2(SIZE),
    parameter int CW    = $clog2(SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH*K-1:0]   par_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH*J-1:0]   par_out,
    output logic                 full,
    output logic                 empty,
    output logic [CW-1:0]        count
);

    localparam logic [BIT:0] SIZE_W   = (BIT+1)'(SIZE);
    localparam logic [BIT:0] K_PTR    = (BIT+1)'(K);
    localparam logic [BIT:0] J_PTR    = (BIT+1)'(J);
    localparam logic [CW:0]  K_CNT    = (CW+1)'(K);
    localparam logic [CW:0]  J_CNT    = (CW+1)'(J);
    localparam logic [CW:0]  FULL_LIM = (CW+1)'(SIZE - K);

    logic [WIDTH-1:0] mem [SIZE];
    logic [BIT-1:0]   wr_ptr;
    logic [BIT-1:0]   rd_ptr;
    logic [BIT-1:0]   wr_addr [K];
    logic [BIT-1:0]   rd_addr [J];
    logic [CW-1:0]    count_nxt;
    logic             wr_en;
    logic             rd_en;

    // Sum is one bit wider than the pointer so a single conditional
    // subtract handles any SIZE, including non-powers of two.
    function automatic logic [BIT-1:0] mod_add(input logic [BIT-1:0] base,
                                               input logic [BIT:0]   inc);
        logic [BIT:0] sum;
        sum = {1'b0, base} + inc;
        if (sum >= SIZE_W)
            sum = sum - SIZE_W;
        return sum[BIT-1:0];
    endfunction

    // Flags depend only on the registered count, so no input reaches an output.
    assign full      = {1'b0, count} > FULL_LIM;
    assign empty     = {1'b0, count} < J_CNT;
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign wr_en = in_valid && in_ready && !flush;
    assign rd_en = out_valid && out_ready && !flush;

    // NOTE: every always_comb output gets a value on every path (defaults or
    // full loop coverage), otherwise synthesis infers a latch.
    always_comb begin
        for (int i = 0; i < K; i++)
            wr_addr[i] = mod_add(wr_ptr, (BIT+1)'(i));
        for (int j = 0; j < J; j++)
            rd_addr[j] = mod_add(rd_ptr, (BIT+1)'(j));
    end

    always_comb begin
        count_nxt = CW'({1'b0, count} + (wr_en ? K_CNT : '0) - (rd_en ? J_CNT : '0));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= mod_add(wr_ptr, K_PTR);
            if (rd_en)
                rd_ptr <= mod_add(rd_ptr, J_PTR);
            count <= count_nxt;
        end
    end

    // NOTE: storage is deliberately left out of reset; its contents are
    // only observable through par_out, which is masked while out_valid = 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < K; i++)
                mem[wr_addr[i]] <= par_in[WIDTH*i +: WIDTH];
        end
    end

    always_comb begin
        par_out = '0;
        if (out_valid) begin
            for (int j = 0; j < J; j++)
                par_out[WIDTH*j +: WIDTH] = mem[rd_addr[j]];
        end
    end

endmodule

// File: tb/tb_multirate_fifo.sv
// Directed bench for multirate_fifo with SIZE=12, K=4, J=3, WIDTH=8.
// Expected values are hand-computed; the wrap test uses a small byte-stream model.
module tb_multirate_fifo;

    localparam int SIZE  = 12;
    localparam int WIDTH = 8;
    localparam int K     = 4;
    localparam int J     = 3;
    localparam int CW    = $clog2(SIZE + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH*K-1:0]   par_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH*J-1:0]   par_out;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;

    int n_checks = 0;
    int n_pass   = 0;

    multirate_fifo #(
        .SIZE (SIZE),
        .WIDTH(WIDTH),
        .K    (K),
        .J    (J)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .par_in   (par_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .par_out  (par_out),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_blk(input logic [31:0] d);
        in_valid = 1'b1;
        par_in   = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic read_blk();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] nb;
        logic [7:0] eb;
        int         sent;
        int         rcvd;
        int         mcount;

        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        par_in    = '0;

        #3;
        check("por_count", 32'(count), 32'd0);
        check("por_empty", 32'(empty), 32'd1);
        check("por_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single block
        write_blk(32'h03020100);
        check("single_count", 32'(count), 32'd4);
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_par_out", 32'(par_out), 32'h020100);
        read_blk();
        check("single_rd_count", 32'(count), 32'd1);
        check("single_rd_out_valid", 32'(out_valid), 32'd0);
        check("single_rd_par_out", 32'(par_out), 32'h0);

        // Fill and backpressure, from a flushed state
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        write_blk(32'h13121110);
        write_blk(32'h17161514);
        check("fill2_count", 32'(count), 32'd8);
        check("fill2_in_ready", 32'(in_ready), 32'd1);
        write_blk(32'h1B1A1918);
        check("fill3_count", 32'(count), 32'd12);
        check("fill3_full", 32'(full), 32'd1);
        check("fill3_in_ready", 32'(in_ready), 32'd0);
        write_blk(32'hEEEEEEEE);
        check("fill4_count", 32'(count), 32'd12);
        check("fill_rd0", 32'(par_out), 32'h121110);
        read_blk();
        check("fill_rd1", 32'(par_out), 32'h151413);
        read_blk();
        check("fill_rd2", 32'(par_out), 32'h181716);
        read_blk();
        check("fill_rd3", 32'(par_out), 32'h1B1A19);
        read_blk();
        check("fill_drain_count", 32'(count), 32'd0);

        // Simultaneous write and read at count = 8 (pointers wrap at 12 here)
        write_blk(32'h23222120);
        write_blk(32'h27262524);
        check("sim_pre_count", 32'(count), 32'd8);
        check("sim_pre_par_out", 32'(par_out), 32'h222120);
        in_valid  = 1'b1;
        par_in    = 32'h2B2A2928;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("sim_count", 32'(count), 32'd9);
        check("sim_in_ready", 32'(in_ready), 32'd0);
        check("sim_rd1", 32'(par_out), 32'h252423);
        read_blk();
        check("sim_rd2", 32'(par_out), 32'h282726);
        read_blk();
        check("sim_rd3", 32'(par_out), 32'h2B2A29);
        read_blk();
        check("sim_drain_count", 32'(count), 32'd0);

        // Wrap-around: 48-byte stream with random handshakes
        nb = 8'h00;
        eb = 8'h00;
        sent = 0;
        rcvd = 0;
        mcount = 0;
        for (int cyc = 0; cyc < 2000 && rcvd < 48; cyc++) begin
            logic do_w;
            logic do_r;
            in_valid  = (sent < 48) && ($urandom_range(0, 3) != 0);
            par_in    = {8'(nb + 8'd3), 8'(nb + 8'd2), 8'(nb + 8'd1), nb};
            out_ready = 1'($urandom_range(0, 1));
            do_w = in_valid && (mcount <= SIZE - K);
            do_r = out_ready && (mcount >= J);
            if (do_r) begin
                check("wrap_data", 32'(par_out), 32'({8'(eb + 8'd2), 8'(eb + 8'd1), eb}));
                eb   = eb + 8'd3;
                rcvd = rcvd + 3;
            end
            if (do_w) begin
                nb   = nb + 8'd4;
                sent = sent + 4;
            end
            mcount = mcount + (do_w ? K : 0) - (do_r ? J : 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("wrap_words_read", 32'(rcvd), 32'd48);
        check("wrap_final_count", 32'(count), 32'd0);
        check("wrap_final_empty", 32'(empty), 32'd1);

        // Flush priority at count = 6
        write_blk(32'h33323130);
        write_blk(32'h37363534);
        write_blk(32'h3B3A3938);
        read_blk();
        read_blk();
        check("flushp_pre_count", 32'(count), 32'd6);
        flush     = 1'b1;
        in_valid  = 1'b1;
        par_in    = 32'h99999999;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flushp_count", 32'(count), 32'd0);
        check("flushp_empty", 32'(empty), 32'd1);
        check("flushp_par_out", 32'(par_out), 32'h0);
        write_blk(32'hDDCCBBAA);
        check("flushp_wr_count", 32'(count), 32'd4);
        check("flushp_wr_par_out", 32'(par_out), 32'hCCBBAA);

        // Reach count = 7, then assert reset mid-cycle
        write_blk(32'h43424140);
        read_blk();
        read_blk();
        write_blk(32'h47464544);
        write_blk(32'h4B4A4948);
        read_blk();
        check("rst_pre_count", 32'(count), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_par_out", 32'(par_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        write_blk(32'h53525150);
        check("post_rst_count", 32'(count), 32'd4);
        check("post_rst_par_out", 32'(par_out), 32'h525150);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
